// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, frame-config bit
// positions and the clock-frequency-derived bit-time table.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int CNT_W    = 19;
    localparam int SW_EIGHT = 2;
    localparam int SW_PEN   = 1;
    localparam int SW_OHEL  = 0;

    // Rounded clock cycles per bit; unused selects fall back to 115200.
    function automatic logic [CNT_W-1:0] baud_count(input int clk_hz, input logic [3:0] sel);
        int rate;
        case (sel)
            4'd0:    rate = 300;
            4'd1:    rate = 1200;
            4'd2:    rate = 2400;
            4'd3:    rate = 4800;
            4'd4:    rate = 9600;
            4'd5:    rate = 19200;
            4'd6:    rate = 38400;
            4'd7:    rate = 57600;
            4'd8:    rate = 115200;
            4'd9:    rate = 230400;
            4'd10:   rate = 460800;
            4'd11:   rate = 921600;
            default: rate = 115200;
        endcase
        return CNT_W'((clk_hz + rate / 2) / rate);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time down-counter: loads a half or full bit period and ticks on the cycle
// before it expires, so the consumer samples exactly on the expiry edge.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_latch,
    input  logic [3:0] i_baud,
    input  logic       i_load_half,
    input  logic       i_load_full,
    output logic       o_tick
);
    logic [3:0]       r_baud;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       w_sel;
    logic [CNT_W-1:0] w_bt;
    logic [CNT_W-1:0] w_bt_tab [16];

    for (genvar g = 0; g < 16; g++) begin : g_bt
        assign w_bt_tab[g] = baud_count(CLK_HZ, 4'(g));
    end

    // The half-bit load happens in the same cycle the select is latched.
    assign w_sel = i_latch ? i_baud : r_baud;
    assign w_bt  = w_bt_tab[w_sel];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_baud <= 4'd0;
        end else if (i_latch) begin
            r_baud <= i_baud;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load_half) begin
            r_cnt <= w_bt >> 1;
        end else if (i_load_full) begin
            r_cnt <= w_bt;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes rx, walks start/data/parity/stop bits and
// holds each finished byte with its error flags until the processor reads it.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    input  logic [3:0] baud,
    input  logic [2:0] switches,
    input  logic       read,
    output logic [7:0] data,
    output logic       rx_rdy,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);
    logic [1:0] r_sync;
    rx_state_t  r_state;
    rx_state_t  w_next;
    logic [2:0] r_sw;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_perr;
    logic       r_done;
    logic [7:0] r_pend_data;
    logic       r_pend_perr;
    logic       r_pend_ferr;
    logic       w_rx_s;
    logic       w_tick;
    logic       w_latch;
    logic       w_load_half;
    logic       w_load_full;
    logic       w_shift_en;
    logic       w_par_en;
    logic       w_stop_en;
    logic       w_last_bit;
    logic [7:0] w_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rx_s = r_sync[1];

    uart_bit_timer #(.CLK_HZ(CLK_HZ)) u_timer (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_latch     (w_latch),
        .i_baud      (baud),
        .i_load_half (w_load_half),
        .i_load_full (w_load_full),
        .o_tick      (w_tick)
    );

    assign w_data     = r_sw[SW_EIGHT] ? r_shift : {1'b0, r_shift[6:0]};
    assign w_last_bit = (r_bit_cnt == (r_sw[SW_EIGHT] ? 3'd7 : 3'd6));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (!w_rx_s) w_next = ST_START;
            ST_START:  if (w_tick) w_next = w_rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_tick && w_last_bit) w_next = r_sw[SW_PEN] ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_tick) w_next = ST_STOP;
            ST_STOP:   if (w_tick) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_latch     = 1'b0;
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_stop_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_latch     = ~w_rx_s;
                w_load_half = ~w_rx_s;
            end
            ST_START:  w_load_full = w_tick & ~w_rx_s;
            ST_DATA: begin
                w_shift_en  = w_tick;
                w_load_full = w_tick;
            end
            ST_PARITY: begin
                w_par_en    = w_tick;
                w_load_full = w_tick;
            end
            ST_STOP:   w_stop_en = w_tick;
            default:   ;
        endcase
    end

    // Finished frame is staged so the next start bit cannot disturb it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sw        <= 3'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_perr      <= 1'b0;
            r_done      <= 1'b0;
            r_pend_data <= 8'd0;
            r_pend_perr <= 1'b0;
            r_pend_ferr <= 1'b0;
        end else begin
            r_done <= w_stop_en;
            if (w_latch) begin
                r_sw      <= switches;
                r_bit_cnt <= 3'd0;
                r_perr    <= 1'b0;
            end else if (w_shift_en) begin
                r_shift[r_bit_cnt] <= w_rx_s;
                r_bit_cnt          <= r_bit_cnt + 1'b1;
            end
            if (w_par_en) begin
                r_perr <= ((^w_data) ^ w_rx_s) != r_sw[SW_OHEL];
            end
            if (w_stop_en) begin
                r_pend_data <= w_data;
                r_pend_perr <= r_sw[SW_PEN] & r_perr;
                r_pend_ferr <= ~w_rx_s;
            end
        end
    end

    // A completing frame takes priority over a read in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data   <= 8'd0;
            rx_rdy <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ovf    <= 1'b0;
        end else if (r_done) begin
            data   <= r_pend_data;
            perr   <= r_pend_perr;
            ferr   <= r_pend_ferr;
            ovf    <= rx_rdy & ~read;
            rx_rdy <= 1'b1;
        end else if (read) begin
            rx_rdy <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ovf    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: serial frames are driven bit by bit and a
// frame-level model predicts the holding register on every cycle.
`timescale 1ns/1ps
module tb_uart_rx_engine;

    logic       clock;
    logic       reset_n;
    logic       rx;
    logic [3:0] baud;
    logic [2:0] switches;
    logic       read;
    logic [7:0] data;
    logic       rx_rdy;
    logic       perr;
    logic       ferr;
    logic       ovf;

    uart_rx_engine #(.CLK_HZ(100_000_000)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rx       (rx),
        .baud     (baud),
        .switches (switches),
        .read     (read),
        .data     (data),
        .rx_rdy   (rx_rdy),
        .perr     (perr),
        .ferr     (ferr),
        .ovf      (ovf)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_comp = -1;
    logic chk_en = 1'b0;

    int bt_tab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                        868, 434, 217, 109, 868, 868, 868, 868};

    // ---------------- frame-level model ----------------
    typedef struct {
        int         c;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } comp_t;

    comp_t      pend[$];
    logic [7:0] m_data;
    logic       m_rdy;
    logic       m_perr;
    logic       m_ferr;
    logic       m_ovf;

    task automatic m_clear();
        m_data = 8'h00;
        m_rdy  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        pend.delete();
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
            if (reset_n) begin
                if (pend.size() != 0 && pend[0].c == cyc) begin
                    m_ovf  = m_rdy & ~read;
                    m_rdy  = 1'b1;
                    m_data = pend[0].d;
                    m_perr = pend[0].pe;
                    m_ferr = pend[0].fe;
                    void'(pend.pop_front());
                end else if (read) begin
                    m_rdy  = 1'b0;
                    m_perr = 1'b0;
                    m_ferr = 1'b0;
                    m_ovf  = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            cmp("cyc_data",   data,         m_data);
            cmp("cyc_rx_rdy", 8'(rx_rdy),   8'(m_rdy));
            cmp("cyc_perr",   8'(perr),     8'(m_perr));
            cmp("cyc_ferr",   8'(ferr),     8'(m_ferr));
            cmp("cyc_ovf",    8'(ovf),      8'(m_ovf));
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_read();
        @(posedge clock);
        #1 read = 1'b1;
        @(posedge clock);
        #1 read = 1'b0;
    endtask

    // abort_bit >= 0 resets the DUT halfway through that data bit;
    // chg_baud >= 0 changes the baud select during data bit 2.
    task automatic send_frame(input logic [7:0] b, input logic [2:0] sw, input logic [3:0] bsel,
                              input logic pbit, input logic stopb, input int abort_bit,
                              input int chg_baud);
        int         bt;
        int         ndata;
        int         n;
        int         t0;
        logic [7:0] dexp;
        comp_t      e;
        bt    = bt_tab[bsel];
        ndata = 7 + int'(sw[2]);
        n     = ndata + int'(sw[1]);
        dexp  = sw[2] ? b : {1'b0, b[6:0]};
        @(posedge clock);
        #1;
        baud     = bsel;
        switches = sw;
        rx       = 1'b0;
        t0       = cyc;
        if (abort_bit < 0) begin
            e.c  = t0 + 4 + bt / 2 + (n + 1) * bt;
            e.d  = dexp;
            e.pe = sw[1] ? (((^dexp) ^ pbit) != sw[0]) : 1'b0;
            e.fe = ~stopb;
            pend.push_back(e);
            last_comp = e.c;
        end
        wait_cycles(bt);
        for (int i = 0; i < n; i++) begin
            rx = (i < ndata) ? b[i] : pbit;
            if (chg_baud >= 0 && i == 2) baud = 4'(chg_baud);
            if (i == abort_bit) begin
                wait_cycles(bt / 2);
                reset_n = 1'b0;
                rx      = 1'b1;
                m_clear();
                wait_cycles(5);
                reset_n = 1'b1;
                wait_cycles(5);
                return;
            end
            wait_cycles(bt);
        end
        rx = stopb;
        wait_cycles(bt);
        rx = 1'b1;
        wait_cycles(10);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int guard;
        reset_n  = 1'b0;
        rx       = 1'b1;
        baud     = 4'd8;
        switches = 3'b100;
        read     = 1'b0;
        wait_cycles(5);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        @(negedge clock);
        cmp("reset_data",   data,       8'h00);
        cmp("reset_rx_rdy", 8'(rx_rdy), 8'h00);
        cmp("reset_perr",   8'(perr),   8'h00);
        cmp("reset_ferr",   8'(ferr),   8'h00);
        cmp("reset_ovf",    8'(ovf),    8'h00);

        // 8N1 at 115200
        send_frame(8'h55, 3'b100, 4'd8, 1'b0, 1'b1, -1, -1);
        @(negedge clock);
        cmp("8n1_data",   data,       8'h55);
        cmp("8n1_rx_rdy", 8'(rx_rdy), 8'h01);
        cmp("8n1_perr",   8'(perr),   8'h00);
        cmp("8n1_ferr",   8'(ferr),   8'h00);
        cmp("8n1_ovf",    8'(ovf),    8'h00);
        pulse_read();
        @(negedge clock);
        cmp("read_rx_rdy", 8'(rx_rdy), 8'h00);
        cmp("read_keeps_data", data, 8'h55);

        // 7O1, correct then wrong parity
        send_frame(8'h41, 3'b011, 4'd11, 1'b1, 1'b1, -1, -1);
        @(negedge clock);
        cmp("7o1_good_data", data,     8'h41);
        cmp("7o1_good_perr", 8'(perr), 8'h00);
        pulse_read();
        send_frame(8'h41, 3'b011, 4'd11, 1'b0, 1'b1, -1, -1);
        @(negedge clock);
        cmp("7o1_bad_perr", 8'(perr), 8'h01);
        pulse_read();

        // framing error
        send_frame(8'hA3, 3'b100, 4'd11, 1'b0, 1'b0, -1, -1);
        @(negedge clock);
        cmp("ferr_data", data,     8'hA3);
        cmp("ferr_flag", 8'(ferr), 8'h01);
        pulse_read();

        // false start: 300-cycle glitch at 115200, then a real frame
        @(posedge clock);
        #1;
        baud = 4'd8;
        rx   = 1'b0;
        wait_cycles(300);
        rx = 1'b1;
        wait_cycles(600);
        @(negedge clock);
        cmp("glitch_rx_rdy", 8'(rx_rdy), 8'h00);
        send_frame(8'h0F, 3'b100, 4'd8, 1'b0, 1'b1, -1, -1);
        @(negedge clock);
        cmp("after_glitch_data", data, 8'h0F);
        pulse_read();

        // overflow
        send_frame(8'h12, 3'b100, 4'd11, 1'b0, 1'b1, -1, -1);
        send_frame(8'h34, 3'b100, 4'd11, 1'b0, 1'b1, -1, -1);
        @(negedge clock);
        cmp("ovf_data", data,       8'h34);
        cmp("ovf_flag", 8'(ovf),    8'h01);
        cmp("ovf_rdy",  8'(rx_rdy), 8'h01);

        // read lands exactly in the completion cycle
        last_comp = -1;
        fork
            send_frame(8'h56, 3'b100, 4'd11, 1'b0, 1'b1, -1, -1);
            begin
                guard = 0;
                while ((last_comp < 0 || cyc != last_comp - 1) && guard < 5000) begin
                    @(negedge clock);
                    guard++;
                end
                if (guard >= 5000) begin
                    total++;
                    bad++;
                    $display("FAIL simul_read_sync: got timeout expected completion cycle");
                end
                read = 1'b1;
                @(posedge clock);
                #1 read = 1'b0;
            end
        join
        @(negedge clock);
        cmp("simul_rdy",  8'(rx_rdy), 8'h01);
        cmp("simul_ovf",  8'(ovf),    8'h00);
        cmp("simul_data", data,       8'h56);
        pulse_read();

        // 7N1 masks bit 7; 8O1 at 230400
        send_frame(8'hFF, 3'b000, 4'd11, 1'b0, 1'b1, -1, -1);
        @(negedge clock);
        cmp("7n1_data", data, 8'h7F);
        pulse_read();
        send_frame(8'h80, 3'b111, 4'd9, 1'b0, 1'b1, -1, -1);
        @(negedge clock);
        cmp("8o1_data", data,     8'h80);
        cmp("8o1_perr", 8'(perr), 8'h00);
        pulse_read();

        // reset during data bit 3, then a clean frame
        send_frame(8'h99, 3'b100, 4'd11, 1'b0, 1'b1, 3, -1);
        @(negedge clock);
        cmp("abort_data",   data,       8'h00);
        cmp("abort_rx_rdy", 8'(rx_rdy), 8'h00);
        send_frame(8'h3C, 3'b100, 4'd11, 1'b0, 1'b1, -1, -1);
        @(negedge clock);
        cmp("post_reset_data", data, 8'h3C);
        pulse_read();

        // baud select changed mid-frame is ignored until the next frame
        send_frame(8'hE7, 3'b100, 4'd8, 1'b0, 1'b1, -1, 4);
        @(negedge clock);
        cmp("baud_chg_data", data,       8'hE7);
        cmp("baud_chg_rdy",  8'(rx_rdy), 8'h01);
        pulse_read();

        wait_cycles(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        bad++;
        $display("FAIL watchdog: got timeout expected sequence end");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Serial receive engine of the UART datapath. It consumes the buffered `rx`, `baud` and `switches` signals from the technology-specific I/O stage and recovers asynchronous serial frames: one start bit, 7 or 8 data bits sent LSB first, optional odd or even parity, and one stop bit. Each completed byte and its error flags are held in a ready/acknowledge register that the TramelBlaze I/O read path drains.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency. The baud table is computed from it.

Ports:
- `clock`  in  1  system clock. All logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, idle high. Asynchronous to `clock`.
- `baud`  in  4  baud-rate select.
- `switches`  in  3  frame configuration:
  - [2] `eight`: 1 = 8 data bits, 0 = 7.
  - [1] `pen`: parity enable.
  - [0] `ohel`: 1 = odd parity, 0 = even.
- `read`  in  1  single-cycle pulse: processor has consumed `data`.
- `data`  out  8  received byte. Bit 7 is 0 in 7-bit mode.
- `rx_rdy`  out  1  a byte is waiting.
- `perr`  out  1  parity error on the held byte.
- `ferr`  out  1  framing error (stop bit sampled 0) on the held byte.
- `ovf`  out  1  a frame completed while `rx_rdy` was still 1.

## Operation
- `rx` goes through a 2-flop synchronizer into `rx_s`. All references to the line below mean `rx_s`.
- Bit time `BT` comes from `baud`, with counts computed as CLK_HZ/rate and rounded:

  | `baud` | rate | `BT` @100 MHz |
  |---|---|---|
  | 0 | 300 | 333333 |
  | 1 | 1200 | 83333 |
  | 2 | 2400 | 41667 |
  | 3 | 4800 | 20833 |
  | 4 | 9600 | 10417 |
  | 5 | 19200 | 5208 |
  | 6 | 38400 | 2604 |
  | 7 | 57600 | 1736 |
  | 8 | 115200 | 868 |
  | 9 | 230400 | 434 |
  | 10 | 460800 | 217 |
  | 11 | 921600 | 109 |
  | 12–15 | 115200 | 868 |

- `baud` and `switches` are latched when a falling edge is detected in IDLE. Changes to either mid-frame have no effect until the next frame.
- Frame length `N` = 7 + `eight` + `pen` bits after the start bit.
- State machine:
  - **IDLE**: on `rx_s` == 0, load the counter with `BT/2` and go to START.
  - **START**: at count expiry, if `rx_s` == 1 it was a false start and the FSM returns to IDLE with no outputs changed. Otherwise load `BT` and go to DATA.
  - **DATA**: at each `BT` expiry, sample `rx_s` into the shift register (LSB first). After the last data bit, go to PARITY if `pen`, else STOP.
  - **PARITY**: sample at `BT` expiry. `perr_n` = (XOR of data bits XOR parity bit) != `ohel`. Go to STOP.
  - **STOP**: sample at `BT` expiry. `ferr_n` = ~`rx_s`. Complete the frame and go to IDLE.
- Frame completion (one cycle after the stop sample):
  - `data`, `perr` and `ferr` are loaded.
  - `rx_rdy` is set to 1.
  - `ovf` is set to `rx_rdy & ~read`.
- `read` clears `rx_rdy`, `perr`, `ferr` and `ovf`. It does not clear `data`.
- If `read` and completion occur in the same cycle, completion wins: `rx_rdy` stays 1, flags are loaded from the new frame, and `ovf` is 0.
- When `pen` is 0, `perr` is always loaded as 0.

## Timing
- Reset values: `data` = 0x00; `rx_rdy`, `perr`, `ferr`, `ovf` = 0; FSM in IDLE; synchronizer flops = 1.
- Reset is asynchronous. Asserting it mid-frame aborts the frame with no partial byte delivered. After release the FSM waits in IDLE for the next falling edge.
- Synchronizer latency is 2 cycles.
- The start sample is taken `BT/2` cycles after the edge is seen. Each later sample is `BT` cycles after the previous one.
- `rx_rdy` rises 1 cycle after the stop-bit sample.
- After completion the FSM is in IDLE and a back-to-back start bit is accepted immediately. The stop sample is at mid-bit, so there is about `BT/2` of margin.
- Counter width is 19 bits, enough to hold 333333.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the baud count function/table, parameterised by `CLK_HZ`;
  - the `switches` bit-index constants.
- Sub-module `uart_bit_timer` holds the latched baud select, the down-counter, the half/full load control and a `tick` output.
- The FSM, shift register and output register stay in `uart_rx_engine`.

## Test plan
- **8N1 byte**: `baud`=8, `switches`=3'b100, drive 0x55 at 868 cycles/bit → `data`=0x55, `rx_rdy`=1, `perr`=`ferr`=`ovf`=0. Then pulse `read` → `rx_rdy`=0 and `data` still 0x55.
- **7O1 parity**: `switches`=3'b011, send 0x41 with parity bit 1 → `perr`=0, `data`=0x41. Repeat with parity bit 0 → `perr`=1.
- **Framing error**: send 0xA3 8N1 with stop bit driven 0 → `ferr`=1, `data`=0xA3.
- **False start**: low glitch of 300 cycles at `baud`=8 → `rx_rdy` stays 0 and the FSM returns to IDLE. The following valid 0x0F frame is received correctly.
- **Overflow and simultaneous read**:
  - Receive two frames without `read` → `ovf`=1 and `data` = second byte.
  - Assert `read` in the completion cycle of a frame → `rx_rdy`=1, `ovf`=0.
- **Reset and baud change mid-frame**:
  - Assert `reset_n`=0 during data bit 3, then release → all outputs are 0 and the next frame is decoded correctly.
  - Change `baud` mid-frame → the current frame is still decoded at the latched rate.
